mem_bus_arbiter: RTL and testbench

- Sits directly downstream of the dcache controller and the icache controller. Multiplexes their requests onto the single processor-to-memory port.
- Records which requester owns each outstanding memory load tag, and routes each returning tag/data to that owner.
- Gives dcache priority, with a starvation guard so icache fetch always makes progress.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates dcache/icache onto one memory port and routes returning
// load tags back to the requester that owns them.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  icache2mem_command,
    input  logic [63:0] icache2mem_addr,
    input  logic [1:0]  dcache2mem_command,
    input  logic [63:0] dcache2mem_addr,
    input  logic [63:0] dcache2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [3:0]  mem2icache_response,
    output logic [3:0]  mem2dcache_response,
    output logic [3:0]  mem2icache_tag,
    output logic [3:0]  mem2dcache_tag,
    output logic [63:0] mem2icache_data,
    output logic [63:0] mem2dcache_data,
    output logic [4:0]  icache_outstanding,
    output logic [4:0]  dcache_outstanding,
    output logic        tag_error
);

    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    // Bit 0 of the owner table is never set: tag 0 means "no tag".
    logic [15:0] owner_valid_q, owner_valid_d;
    logic [15:0] owner_dc_q, owner_dc_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        tag_error_q, tag_error_d;

    logic icache_req;
    logic dcache_req;
    logic force_i;
    logic gnt_i;
    logic gnt_d;
    logic accepted;
    logic ret_hit;

    always_comb begin
        icache_req = (icache2mem_command != 2'd0);
        dcache_req = (dcache2mem_command != 2'd0);
        force_i    = icache_req && (starve_cnt_q >= LIMIT);
        gnt_d      = dcache_req && !force_i;
        gnt_i      = icache_req && !gnt_d;
        accepted   = (mem2proc_response != 4'd0);
    end

    always_comb begin
        proc2mem_command    = 2'd0;
        proc2mem_addr       = 64'd0;
        proc2mem_data       = 64'd0;
        mem2icache_response = 4'd0;
        mem2dcache_response = 4'd0;
        if (gnt_d) begin
            proc2mem_command    = dcache2mem_command;
            proc2mem_addr       = dcache2mem_addr;
            proc2mem_data       = dcache2mem_data;
            mem2dcache_response = mem2proc_response;
        end else if (gnt_i) begin
            proc2mem_command    = icache2mem_command;
            proc2mem_addr       = icache2mem_addr;
            mem2icache_response = mem2proc_response;
        end
    end

    always_comb begin
        ret_hit        = (mem2proc_tag != 4'd0) && owner_valid_q[mem2proc_tag];
        mem2icache_tag = 4'd0;
        mem2dcache_tag = 4'd0;
        if (ret_hit) begin
            if (owner_dc_q[mem2proc_tag]) begin
                mem2dcache_tag = mem2proc_tag;
            end else begin
                mem2icache_tag = mem2proc_tag;
            end
        end
    end

    assign mem2icache_data = mem2proc_data;
    assign mem2dcache_data = mem2proc_data;
    assign tag_error       = tag_error_q;

    always_comb begin
        owner_valid_d = owner_valid_q;
        owner_dc_d    = owner_dc_q;
        tag_error_d   = tag_error_q;
        starve_cnt_d  = starve_cnt_q;

        // Retire first so a same-cycle reissue of the tag wins.
        if (mem2proc_tag != 4'd0) begin
            if (!owner_valid_q[mem2proc_tag]) begin
                tag_error_d = 1'b1;
            end
            owner_valid_d[mem2proc_tag] = 1'b0;
        end
        if ((proc2mem_command == BUS_LOAD) && accepted) begin
            owner_valid_d[mem2proc_response] = 1'b1;
            owner_dc_d[mem2proc_response]    = gnt_d;
        end

        if (!icache_req || (gnt_i && accepted)) begin
            starve_cnt_d = 8'd0;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_comb begin
        icache_outstanding = 5'd0;
        dcache_outstanding = 5'd0;
        for (int i = 1; i < 16; i++) begin
            if (owner_valid_q[i]) begin
                if (owner_dc_q[i]) begin
                    dcache_outstanding = dcache_outstanding + 5'd1;
                end else begin
                    icache_outstanding = icache_outstanding + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_valid_q <= 16'd0;
            owner_dc_q    <= 16'd0;
            starve_cnt_q  <= 8'd0;
            tag_error_q   <= 1'b0;
        end else begin
            owner_valid_q <= owner_valid_d;
            owner_dc_q    <= owner_dc_d;
            starve_cnt_q  <= starve_cnt_d;
            tag_error_q   <= tag_error_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic
// compared every cycle against an owner-table reference model.
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  icache2mem_command = '0;
    logic [63:0] icache2mem_addr = '0;
    logic [1:0]  dcache2mem_command = '0;
    logic [63:0] dcache2mem_addr = '0;
    logic [63:0] dcache2mem_data = '0;
    logic [3:0]  mem2proc_response = '0;
    logic [63:0] mem2proc_data = '0;
    logic [3:0]  mem2proc_tag = '0;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2icache_response;
    logic [3:0]  mem2dcache_response;
    logic [3:0]  mem2icache_tag;
    logic [3:0]  mem2dcache_tag;
    logic [63:0] mem2icache_data;
    logic [63:0] mem2dcache_data;
    logic [4:0]  icache_outstanding;
    logic [4:0]  dcache_outstanding;
    logic        tag_error;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .icache2mem_command(icache2mem_command),
        .icache2mem_addr(icache2mem_addr),
        .dcache2mem_command(dcache2mem_command),
        .dcache2mem_addr(dcache2mem_addr),
        .dcache2mem_data(dcache2mem_data),
        .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2icache_response(mem2icache_response),
        .mem2dcache_response(mem2dcache_response),
        .mem2icache_tag(mem2icache_tag),
        .mem2dcache_tag(mem2dcache_tag),
        .mem2icache_data(mem2icache_data),
        .mem2dcache_data(mem2dcache_data),
        .icache_outstanding(icache_outstanding),
        .dcache_outstanding(dcache_outstanding),
        .tag_error(tag_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: owner per tag (0 none, 1 icache, 2 dcache), lost-cycle count.
    int m_owner [16];
    int m_starve = 0;
    bit m_err = 1'b0;

    initial foreach (m_owner[i]) m_owner[i] = 0;

    function automatic int side();
        bit ir;
        bit dr;
        ir = (icache2mem_command != 2'd0);
        dr = (dcache2mem_command != 2'd0);
        if (dr && !(ir && m_starve >= LIMIT)) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    always @(posedge clock) begin : model
        int s;
        int r;
        int t;
        int gcmd;
        if (reset) begin
            foreach (m_owner[i]) m_owner[i] = 0;
            m_starve = 0;
            m_err = 1'b0;
        end else begin
            s = side();
            r = int'(mem2proc_response);
            t = int'(mem2proc_tag);
            gcmd = (s == 2) ? int'(dcache2mem_command) :
                   (s == 1) ? int'(icache2mem_command) : 0;
            if (icache2mem_command == 2'd0 || (s == 1 && r != 0))
                m_starve = 0;
            else if (m_starve < 255)
                m_starve = m_starve + 1;
            if (t != 0) begin
                if (m_owner[t] == 0) m_err = 1'b1;
                m_owner[t] = 0;
            end
            if (r != 0 && gcmd == 1) m_owner[r] = s;
        end
    end

    always @(negedge clock) begin : cmp
        int s;
        int t;
        int ni;
        int nd;
        logic [63:0] ecmd;
        logic [63:0] eaddr;
        logic [63:0] edata;
        s = side();
        ecmd = '0;
        eaddr = '0;
        edata = '0;
        if (s == 2) begin
            ecmd = 64'(dcache2mem_command);
            eaddr = dcache2mem_addr;
            edata = dcache2mem_data;
        end else if (s == 1) begin
            ecmd = 64'(icache2mem_command);
            eaddr = icache2mem_addr;
        end
        chk("cmd", 64'(proc2mem_command), ecmd);
        chk("addr", proc2mem_addr, eaddr);
        chk("wdata", proc2mem_data, edata);
        chk("i_resp", 64'(mem2icache_response),
            (s == 1) ? 64'(mem2proc_response) : 64'd0);
        chk("d_resp", 64'(mem2dcache_response),
            (s == 2) ? 64'(mem2proc_response) : 64'd0);
        t = int'(mem2proc_tag);
        chk("i_tag", 64'(mem2icache_tag),
            (t != 0 && m_owner[t] == 1) ? 64'(t) : 64'd0);
        chk("d_tag", 64'(mem2dcache_tag),
            (t != 0 && m_owner[t] == 2) ? 64'(t) : 64'd0);
        chk("i_data", mem2icache_data, mem2proc_data);
        chk("d_data", mem2dcache_data, mem2proc_data);
        ni = 0;
        nd = 0;
        foreach (m_owner[i]) begin
            if (m_owner[i] == 1) ni++;
            if (m_owner[i] == 2) nd++;
        end
        chk("i_out", 64'(icache_outstanding), 64'(ni));
        chk("d_out", 64'(dcache_outstanding), 64'(nd));
        chk("tag_err", 64'(tag_error), 64'(m_err));
    end

    task automatic drive(input logic [1:0] ic, input logic [63:0] ia,
                         input logic [1:0] dc, input logic [63:0] da,
                         input logic [63:0] dd, input logic [3:0] rsp,
                         input logic [3:0] tg, input logic [63:0] md);
        @(posedge clock);
        #1;
        icache2mem_command = ic;
        icache2mem_addr = ia;
        dcache2mem_command = dc;
        dcache2mem_addr = da;
        dcache2mem_data = dd;
        mem2proc_response = rsp;
        mem2proc_tag = tg;
        mem2proc_data = md;
        #2;
    endtask

    task automatic idle();
        drive(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    endtask

    initial begin
        logic [3:0] rsp;
        logic [3:0] tg;
        reset = 1'b1;
        idle();
        idle();
        chk("lit_rst_cmd", 64'(proc2mem_command), 64'd0);
        chk("lit_rst_iout", 64'(icache_outstanding), 64'd0);
        chk("lit_rst_dout", 64'(dcache_outstanding), 64'd0);
        chk("lit_rst_err", 64'(tag_error), 64'd0);
        reset = 1'b0;

        drive(2'd1, 64'h1000, 2'd0, 64'd0, 64'd0, 4'd3, 4'd0, 64'd0);
        chk("lit_i_cmd", 64'(proc2mem_command), 64'd1);
        chk("lit_i_addr", proc2mem_addr, 64'h1000);
        chk("lit_i_iresp", 64'(mem2icache_response), 64'd3);
        chk("lit_i_dresp", 64'(mem2dcache_response), 64'd0);
        idle();
        chk("lit_i_out1", 64'(icache_outstanding), 64'd1);

        drive(2'd1, 64'h1004, 2'd2, 64'h2000, 64'hAB, 4'd5, 4'd0, 64'd0);
        chk("lit_st_cmd", 64'(proc2mem_command), 64'd2);
        chk("lit_st_data", proc2mem_data, 64'hAB);
        chk("lit_st_dresp", 64'(mem2dcache_response), 64'd5);
        chk("lit_st_iresp", 64'(mem2icache_response), 64'd0);
        idle();
        chk("lit_st_dout", 64'(dcache_outstanding), 64'd0);

        for (int k = 0; k < 6; k++) begin
            drive(2'd1, 64'h3000, 2'd2, 64'h4000 + 64'(k), 64'(k),
                  4'd2, 4'd0, 64'd0);
            chk("lit_starve_cmd", 64'(proc2mem_command),
                (k == 4) ? 64'd1 : 64'd2);
        end

        drive(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd3, 64'h33);
        chk("lit_ret3_i", 64'(mem2icache_tag), 64'd3);
        chk("lit_ret3_d", 64'(mem2dcache_tag), 64'd0);
        drive(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd2, 64'h22);
        chk("lit_ret2_i", 64'(mem2icache_tag), 64'd2);
        idle();
        chk("lit_iout0", 64'(icache_outstanding), 64'd0);

        drive(2'd0, 64'd0, 2'd1, 64'h5000, 64'd0, 4'd7, 4'd0, 64'd0);
        chk("lit_dld_resp", 64'(mem2dcache_response), 64'd7);
        idle();
        chk("lit_dld_out", 64'(dcache_outstanding), 64'd1);
        drive(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd7, 64'hDEAD);
        chk("lit_ret7_d", 64'(mem2dcache_tag), 64'd7);
        chk("lit_ret7_i", 64'(mem2icache_tag), 64'd0);
        chk("lit_ret7_data", mem2dcache_data, 64'hDEAD);
        idle();
        chk("lit_ret7_out", 64'(dcache_outstanding), 64'd0);

        drive(2'd1, 64'h6000, 2'd0, 64'd0, 64'd0, 4'd7, 4'd0, 64'd0);
        idle();
        chk("lit_ild_out", 64'(icache_outstanding), 64'd1);
        drive(2'd0, 64'd0, 2'd1, 64'h7000, 64'd0, 4'd7, 4'd7, 64'h77);
        chk("lit_swap_i", 64'(mem2icache_tag), 64'd7);
        chk("lit_swap_d", 64'(mem2dcache_tag), 64'd0);
        chk("lit_swap_resp", 64'(mem2dcache_response), 64'd7);
        idle();
        chk("lit_swap_iout", 64'(icache_outstanding), 64'd0);
        chk("lit_swap_dout", 64'(dcache_outstanding), 64'd1);

        drive(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd9, 64'h99);
        chk("lit_t9_i", 64'(mem2icache_tag), 64'd0);
        chk("lit_t9_d", 64'(mem2dcache_tag), 64'd0);
        idle();
        chk("lit_err_set", 64'(tag_error), 64'd1);
        idle();
        chk("lit_err_hold", 64'(tag_error), 64'd1);
        reset = 1'b1;
        idle();
        chk("lit_err_clr", 64'(tag_error), 64'd0);
        chk("lit_rst_dout2", 64'(dcache_outstanding), 64'd0);
        reset = 1'b0;
        drive(2'd0, 64'd0, 2'd0, 64'd0, 64'd0, 4'd0, 4'd7, 64'h7);
        chk("lit_stale7_d", 64'(mem2dcache_tag), 64'd0);
        idle();
        chk("lit_stale7_err", 64'(tag_error), 64'd1);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            rsp = ($urandom_range(0, 9) < 3) ? 4'd0
                                             : 4'($urandom_range(1, 15));
            tg = ($urandom_range(0, 1) == 0) ? 4'd0
                                             : 4'($urandom_range(0, 15));
            drive(2'($urandom_range(0, 1)), {$urandom, $urandom},
                  2'($urandom_range(0, 2)), {$urandom, $urandom},
                  {$urandom, $urandom}, rsp, tg, {$urandom, $urandom});
        end
        reset = 1'b0;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
